// File: rtl/uart_rx_nbyte.sv
// uart_rx_nbyte: receiver for the N-byte UART burst format, fixed at 2 clocks per bit.
//
// Line format: MSB first, 2 cycles per data bit, 2-cycle high stop bit.
// The first byte of a burst is preceded by 3 low cycles (wake + start) and
// every following byte by 2 low cycles. Burst length is bytes_to_rx+1.
//
// Ports:
//   clock           in   single clock, posedge
//   reset_n         in   synchronous active-low reset
//   serial_data_in  in   serial line, idle high, synchronous to clock
//   bytes_to_rx     in   [9:0] burst length minus one, latched at start detection
//   rx_data_byte    out  [7:0] last received byte, held until the next one
//   rx_data_valid   out  one-cycle pulse, rx_data_byte is new
//   rx_burst_done   out  one-cycle pulse together with the final byte's valid
//   rx_busy         out  high from start detection until end of burst or abort
//   rx_frame_err    out  one-cycle pulse on a low stop sample
//                        (present only when UART_RX_FRAME_ERR_EN is defined)
//
// Optional feature macro: UART_RX_FRAME_ERR_EN enables stop-bit checking and
// the rx_frame_err port; without it the stop bit is not checked.

module uart_rx_nbyte (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_data_in,
    input  logic [9:0] bytes_to_rx,
    output logic [7:0] rx_data_byte,
    output logic       rx_data_valid,
    output logic       rx_burst_done,
    output logic       rx_busy
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       rx_frame_err
`endif
);

    localparam int unsigned CNT_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BIT_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        START,
        DATA,
        STOP,
        GAP
    } state_t;

    state_t              state, state_d;
    logic                armed, armed_d;
    logic                wake_two, wake_two_d;
    logic                half, half_d;
    logic [BIT_W-1:0]    bit_idx, bit_idx_d;
    logic [BYTE_W-1:0]   shreg, shreg_d;
    logic [CNT_W-1:0]    n_bytes, n_bytes_d;
    logic [CNT_W-1:0]    rx_count, rx_count_d;
    logic [BYTE_W-1:0]   byte_d;
    logic                valid_d;
    logic                done_d;
    logic                busy_d;
    logic                last_byte_c;
`ifdef UART_RX_FRAME_ERR_EN
    logic                ferr_d;
`endif

    assign last_byte_c = ((rx_count + CNT_W'(1)) == n_bytes);

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            armed         <= 1'b0;
            wake_two      <= 1'b0;
            half          <= 1'b0;
            bit_idx       <= '0;
            shreg         <= '0;
            n_bytes       <= '0;
            rx_count      <= '0;
            rx_data_byte  <= '0;
            rx_data_valid <= 1'b0;
            rx_burst_done <= 1'b0;
            rx_busy       <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            rx_frame_err  <= 1'b0;
`endif
        end else begin
            state         <= state_d;
            armed         <= armed_d;
            wake_two      <= wake_two_d;
            half          <= half_d;
            bit_idx       <= bit_idx_d;
            shreg         <= shreg_d;
            n_bytes       <= n_bytes_d;
            rx_count      <= rx_count_d;
            rx_data_byte  <= byte_d;
            rx_data_valid <= valid_d;
            rx_burst_done <= done_d;
            rx_busy       <= busy_d;
`ifdef UART_RX_FRAME_ERR_EN
            rx_frame_err  <= ferr_d;
`endif
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        armed_d    = armed;
        wake_two_d = wake_two;
        half_d     = half;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        n_bytes_d  = n_bytes;
        rx_count_d = rx_count;
        byte_d     = rx_data_byte;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        busy_d     = rx_busy;
`ifdef UART_RX_FRAME_ERR_EN
        ferr_d     = 1'b0;
`endif

        case (state)
            IDLE: begin
                // A start is only accepted after the line has been seen high.
                if (serial_data_in) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    state_d    = WAKE;
                    armed_d    = 1'b0;
                    wake_two_d = 1'b1;
                    n_bytes_d  = CNT_W'(bytes_to_rx) + CNT_W'(1);
                    rx_count_d = '0;
                    busy_d     = 1'b1;
                end
            end

            // First byte needs two more low samples, later bytes need one.
            WAKE: begin
                if (serial_data_in) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (wake_two) begin
                    wake_two_d = 1'b0;
                end else begin
                    state_d = START;
                end
            end

            // One unsampled cycle so data is taken mid-bit.
            START: begin
                state_d   = DATA;
                half_d    = 1'b0;
                bit_idx_d = '0;
            end

            // Sample on every other edge, MSB first.
            DATA: begin
                half_d = ~half;
                if (!half) begin
                    shreg_d = {shreg[BYTE_W-2:0], serial_data_in};
                    if (bit_idx == BIT_W'(7)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + BIT_W'(1);
                    end
                end
            end

            // Stop check falls two edges after the last data sample.
            STOP: begin
                if (half) begin
                    half_d = 1'b0;
                end else begin
`ifdef UART_RX_FRAME_ERR_EN
                    if (!serial_data_in) begin
                        ferr_d  = 1'b1;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else
`endif
                    begin
                        byte_d     = shreg;
                        valid_d    = 1'b1;
                        rx_count_d = rx_count + CNT_W'(1);
                        if (last_byte_c) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end

            GAP: begin
                if (!serial_data_in) begin
                    state_d    = WAKE;
                    wake_two_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_rx_nbyte.md
UART_RX_NBYTE -- requirements
Module: uart_rx_nbyte

Interface
REQ-001 Parameters: none; all timing is fixed at 2 clocks per bit.
REQ-002 clock  input  1  single clock; all logic on posedge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 serial_data_in  input  1  serial line, synchronous to clock, idle high, driven by the N-byte UART transmitter.
REQ-005 bytes_to_rx  input  10  (N-1) bytes per burst, 1..1024.
REQ-006 rx_data_byte  output  8  last received byte.
REQ-007 rx_data_valid  output  1  one-cycle pulse: rx_data_byte is new.
REQ-008 rx_burst_done  output  1  one-cycle pulse with the final byte's rx_data_valid.
REQ-009 rx_busy  output  1  high from start detection to end of burst or abort.
REQ-010 rx_frame_err  output  1  one-cycle pulse on a bad stop bit; present only with UART_RX_FRAME_ERR_EN.

Function
REQ-011 Line format SHALL be: MSB first, each data bit 2 cycles, stop bit high for 2 cycles.
REQ-012 The first byte of a burst SHALL be preceded by 3 low cycles (wake plus start).
REQ-013 Each subsequent byte SHALL be preceded by 2 low cycles.
REQ-014 States SHALL be: IDLE, WAKE, START, DATA, STOP, GAP.
REQ-015 IDLE, first sample edge S0 with line low and armed=1: go to WAKE; latch N = bytes_to_rx+1 (11-bit count); assert rx_busy.
REQ-016 armed SHALL be set by any high sample in IDLE and cleared on leaving IDLE.
REQ-017 WAKE SHALL require low samples at S0+1 and S0+2; any high sample SHALL return to IDLE with rx_busy deasserted and no output pulses.
REQ-018 First byte: bit k SHALL be sampled at S0+4+2*(7-k), so bit7 at S0+4 and bit0 at S0+18; stop SHALL be checked at S0+20.
REQ-019 GAP: wait any number of cycles for a low sample S1; S1+1 must also sample low, else return to IDLE and deassert rx_busy with no pulse.
REQ-020 Subsequent byte: bit k SHALL be sampled at S1+3+2*(7-k); stop SHALL be checked at S1+19.
REQ-021 rx_data_byte and rx_data_valid SHALL be registered; the pulse is visible the cycle after the stop-check edge.
REQ-022 rx_data_byte SHALL hold its value until the next valid byte.
REQ-023 Back-to-back bytes from the transmitter SHALL produce rx_data_valid pulses exactly 20 cycles apart.
REQ-024 After the Nth byte: pulse rx_burst_done with rx_data_valid, deassert rx_busy in the same cycle, return to IDLE.
REQ-025 Otherwise after a byte: go to GAP.
REQ-026 Changes to bytes_to_rx while rx_busy=1 SHALL be ignored.
REQ-027 Received-byte count SHALL be 11 bits; N=1024 SHALL NOT wrap.
REQ-028 Shift register SHALL be loaded only at the defined sample edges.

Reset
REQ-029 reset_n low at a posedge SHALL set: state=IDLE, armed=0, byte count=0, shift register=0x00.
REQ-030 Output reset values SHALL be: rx_data_byte=0x00, rx_data_valid=0, rx_burst_done=0, rx_busy=0, rx_frame_err=0.
REQ-031 Reset mid-burst SHALL discard the partial byte with no pulses.
REQ-032 After reset, a new start SHALL be recognised only after at least one high sample.

Configuration
REQ-033 Macro UART_RX_FRAME_ERR_EN defined: a low stop sample SHALL pulse rx_frame_err.
REQ-034 In that case the block SHALL suppress rx_data_valid and rx_burst_done, keep rx_data_byte unchanged, abort the burst (IDLE, rx_busy=0, armed=0).
REQ-035 Macro undefined: the stop bit SHALL NOT be checked, every byte SHALL be delivered, and the rx_frame_err port SHALL be absent.

Verification
REQ-036 bytes_to_rx=0, transmit 0xA5 -> one rx_data_valid with 0xA5 visible after S0+20; rx_burst_done in the same cycle; rx_busy low afterwards.
REQ-037 bytes_to_rx=2, burst 0x00,0xFF,0x3C -> three valid pulses 20 cycles apart, correct bytes in order; rx_burst_done only on 0x3C.
REQ-038 Line low for 1 sample, then high -> no pulses; rx_busy returns to 0 within 2 cycles.
REQ-039 Byte 0x81 with stop sample forced low -> macro on: rx_frame_err=1 for 1 cycle, no valid, rx_data_byte unchanged. Macro off: valid with 0x81.
REQ-040 reset_n low for 1 cycle at S0+10 of byte 0x5A, line then held high 4 cycles and 0x5A resent -> no output from the first frame; exactly one valid with 0x5A.
REQ-041 bytes_to_rx=1 at burst start, changed to 5 after the first byte -> exactly 2 bytes received, then IDLE.
